regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port register file with an integrated write-pending scoreboard, for the datapath's operand-fetch stage. It generalises the single-issue 32x64 file to configurable width, depth and read-port count, and keeps a hardwired constant register. A busy bit per register lets issue logic reserve a destination and detect read-after-write hazards until the matching writeback arrives.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of independent read ports
- ZERO_REG, 31, index of the hardwired register: reads 0, never written, never busy

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all registers, busy bits and PendCnt
- RA  in  NREAD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- BusA  out  NREAD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- RdBusy  out  NREAD  busy flag of the register addressed by each read port
- RW  in  ADDR_W  write address
- BusW  in  DATA_W  write data
- RegWr  in  1  write enable
- Reserve  in  1  mark register ResAddr busy
- ResAddr  in  ADDR_W  register to reserve
- PendCnt  out  ADDR_W+1  registered count of busy registers
- WrNoRes  out  1  registered one-cycle pulse: the previous cycle wrote a non-busy register (RW != ZERO_REG)

## Operation
- Storage: 2**ADDR_W x DATA_W flops; all 0 after Reset.
- Read: combinational per port; BusA_i = regs[RA_i]; RA_i == ZERO_REG gives 0 regardless of storage.
- Write: RegWr=1 and RW != ZERO_REG -> regs[RW] <= BusW at rising edge. Writes to ZERO_REG are dropped silently.
- Scoreboard, at each rising edge:
  - RegWr=1 clears busy[RW].
  - Reserve=1 and ResAddr != ZERO_REG sets busy[ResAddr].
  - Same address reserved and written in one cycle: set wins, so the register ends busy. This is the back-to-back reuse case.
- RdBusy_i = busy[RA_i]; always 0 for ZERO_REG.
- PendCnt: next value is the popcount of next-state busy; holds 0..2**ADDR_W-1; never wraps because ZERO_REG cannot be busy.
- WrNoRes: set for one cycle after an edge where RegWr=1, RW != ZERO_REG and busy[RW] was 0. It flags diagnostics only; the write still happens.

## Timing
- Read latency: 0 cycles (combinational).
- Write, reserve and clear take effect at the rising edge. The new value is visible on BusA in the following cycle, or the same cycle with bypass (see Configuration).
- PendCnt and WrNoRes are valid 1 cycle after the causing edge.
- Reset outputs: BusA = 0 on all ports, RdBusy = 0, PendCnt = 0, WrNoRes = 0.
- Reset asserted mid-operation clears state immediately. Inputs are ignored while Reset=1. The first edge after deassertion acts normally.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If RegWr=1, RW == RA_i and RW != ZERO_REG, then BusA_i = BusW and RdBusy_i = 0 in the same cycle. If Reserve targets that same address, RdBusy_i stays 1.
  - This is a combinational path from BusW and RW to BusA.
- Not defined: reads return the stored value and current busy bit. The write appears next cycle.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W/NREAD/ZERO_REG constants and a popcount function.
- One sub-module, regfile_scoreboard_busy: holds the busy vector, the set/clear priority logic, PendCnt and WrNoRes.
- Storage and read muxes stay in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports -> every BusA = 0, RdBusy = 0, PendCnt = 0.
- Write 64'hDEAD_BEEF_0123_4567 to R5, read R5 next cycle -> that value. Write 64'hFFFF to R31, read R31 -> 0.
- Reserve R7, one cycle later read R7 -> RdBusy = 1, PendCnt = 1. Write R7 = 9 -> next cycle RdBusy = 0, PendCnt = 0, BusA = 9.
- Same cycle: Reserve R3 and write R3 = 1 (R3 not busy) -> R3 = 1, busy, PendCnt = 1, WrNoRes pulses once.
- Write R4 = 42 while RA0 = 4, same cycle -> BusA0 = 42 with REGFILE_BYPASS_EN defined, old value without it.
- Reserve R1, R2, R6, assert Reset between edges -> PendCnt = 0, RdBusy = 0 and R1 reads 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and popcount helper for the register file / scoreboard.
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 31;

  // Widest busy vector the helper accepts (ADDR_W up to 8).
  localparam int POP_MAX = 256;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_busy.sv
// regfile_scoreboard_busy: per-register busy bits with set-over-clear priority,
// registered pending count and write-to-non-reserved diagnostic pulse.
`default_nettype none

module regfile_scoreboard_busy
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  res_en,
  input  logic [ADDR_W-1:0]     res_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  wr_no_res
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_nxt;
  logic             wr_no_res_nxt;

  // Reserve is applied after the writeback clear so a same-cycle reuse stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (res_en && (res_addr != ZERO_ADDR)) begin
      busy_nxt[res_addr] = 1'b1;
    end
  end

  always_comb begin
    wr_no_res_nxt = wr_en && (wr_addr != ZERO_ADDR) && !busy[wr_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      pend_cnt  <= '0;
      wr_no_res <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      pend_cnt  <= (ADDR_W+1)'(popcount(POP_MAX'(busy_nxt)));
      wr_no_res <= wr_no_res_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with hardwired zero register and
// write-pending scoreboard. Optional macro REGFILE_BYPASS_EN forwards same-cycle writes.
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREAD*ADDR_W-1:0] RA,
  output logic [NREAD*DATA_W-1:0] BusA,
  output logic [NREAD-1:0]        RdBusy,
  input  logic [ADDR_W-1:0]       RW,
  input  logic [DATA_W-1:0]       BusW,
  input  logic                    RegWr,
  input  logic                    Reserve,
  input  logic [ADDR_W-1:0]       ResAddr,
  output logic [ADDR_W:0]         PendCnt,
  output logic                    WrNoRes
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  regfile_scoreboard_busy #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk       (Clk),
    .rst       (Reset),
    .wr_en     (RegWr),
    .wr_addr   (RW),
    .res_en    (Reserve),
    .res_addr  (ResAddr),
    .busy      (busy),
    .pend_cnt  (PendCnt),
    .wr_no_res (WrNoRes)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWr && (RW != ZERO_ADDR)) begin
      regs[RW] <= BusW;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [ADDR_W-1:0] ra;
    assign ra = RA[p*ADDR_W +: ADDR_W];

    always_comb begin
      BusA[p*DATA_W +: DATA_W] = regs[ra];
      RdBusy[p]                = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle reserve of the written register keeps it visibly busy.
      if (RegWr && (RW == ra) && (RW != ZERO_ADDR)) begin
        BusA[p*DATA_W +: DATA_W] = BusW;
        RdBusy[p]                = Reserve && (ResAddr == ra);
      end
`endif
      if (ra == ZERO_ADDR) begin
        BusA[p*DATA_W +: DATA_W] = '0;
        RdBusy[p]                = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard-driven self-checking bench for regfile_scoreboard.
`default_nettype none

module tb_regfile_scoreboard;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [9:0]   RA;
  logic [127:0] BusA;
  logic [1:0]   RdBusy;
  logic [4:0]   RW;
  logic [63:0]  BusW;
  logic         RegWr;
  logic         Reserve;
  logic [4:0]   ResAddr;
  logic [5:0]   PendCnt;
  logic         WrNoRes;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;

  regfile_scoreboard dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .RA      (RA),
    .BusA    (BusA),
    .RdBusy  (RdBusy),
    .RW      (RW),
    .BusW    (BusW),
    .RegWr   (RegWr),
    .Reserve (Reserve),
    .ResAddr (ResAddr),
    .PendCnt (PendCnt),
    .WrNoRes (WrNoRes)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();
    RegWr = 1'b0; Reserve = 1'b0; RW = '0; ResAddr = '0; BusW = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(); RA = '0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      RA = {5'(31 - a), 5'(a)};
      sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL reset_busa0[%0d]: got %h expected %h", a, BusA[63:0], exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (BusA[127:64] !== exp_v) begin errors++; $display("FAIL reset_busa1[%0d]: got %h expected %h", a, BusA[127:64], exp_v); end
      exp_v = sb.pop_front(); checks++;
      if ({62'b0, RdBusy} !== exp_v) begin errors++; $display("FAIL reset_rdbusy[%0d]: got %b expected %h", a, RdBusy, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if ({57'b0, WrNoRes, PendCnt} !== exp_v) begin errors++; $display("FAIL reset_pend[%0d]: got %0d/%b expected %h", a, PendCnt, WrNoRes, exp_v); end
    end
  endtask

  task automatic test_write_read();
    RA = '0;
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD_BEEF_0123_4567;
    sb.push_back(64'hDEAD_BEEF_0123_4567); sb.push_back(64'h1);
    tick();
    idle(); RA = {5'd0, 5'd5}; #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL write_r5: got %h expected %h", BusA[63:0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, WrNoRes} !== exp_v) begin errors++; $display("FAIL wrnores_r5: got %b expected %h", WrNoRes, exp_v); end
    RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF;
    sb.push_back(64'h0); sb.push_back(64'h0);
    tick();
    idle(); RA = {5'd31, 5'd31}; #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[127:64] !== exp_v) begin errors++; $display("FAIL write_r31: got %h expected %h", BusA[127:64], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, WrNoRes} !== exp_v) begin errors++; $display("FAIL wrnores_r31: got %b expected %h", WrNoRes, exp_v); end
  endtask

  task automatic test_reserve_clear();
    RA = '0; Reserve = 1'b1; ResAddr = 5'd7;
    sb.push_back(64'h1); sb.push_back(64'h1);
    tick();
    idle(); RA = {5'd0, 5'd7}; #1;
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, RdBusy[0]} !== exp_v) begin errors++; $display("FAIL reserve_busy: got %b expected %h", RdBusy[0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL reserve_pend: got %0d expected %0d", PendCnt, exp_v); end
    RA = '0; RegWr = 1'b1; RW = 5'd7; BusW = 64'd9;
    sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'd9); sb.push_back(64'h0);
    tick();
    idle(); RA = {5'd0, 5'd7}; #1;
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, RdBusy[0]} !== exp_v) begin errors++; $display("FAIL clear_busy: got %b expected %h", RdBusy[0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL clear_pend: got %0d expected %0d", PendCnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL clear_data: got %h expected %h", BusA[63:0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, WrNoRes} !== exp_v) begin errors++; $display("FAIL clear_wrnores: got %b expected %h", WrNoRes, exp_v); end
  endtask

  task automatic test_back_to_back();
    RA = '0; Reserve = 1'b1; ResAddr = 5'd3; RegWr = 1'b1; RW = 5'd3; BusW = 64'd1;
    sb.push_back(64'd1); sb.push_back(64'h1); sb.push_back(64'h1); sb.push_back(64'h1); sb.push_back(64'h0);
    tick();
    idle(); RA = {5'd0, 5'd3}; #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL b2b_data: got %h expected %h", BusA[63:0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, RdBusy[0]} !== exp_v) begin errors++; $display("FAIL b2b_busy: got %b expected %h", RdBusy[0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL b2b_pend: got %0d expected %0d", PendCnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, WrNoRes} !== exp_v) begin errors++; $display("FAIL b2b_wrnores: got %b expected %h", WrNoRes, exp_v); end
    tick();
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, WrNoRes} !== exp_v) begin errors++; $display("FAIL b2b_pulse_once: got %b expected %h", WrNoRes, exp_v); end
    RegWr = 1'b1; RW = 5'd3; BusW = 64'd1; RA = '0;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    RA = '0; RegWr = 1'b1; RW = 5'd4; BusW = 64'd11;
    tick();
    RegWr = 1'b1; RW = 5'd4; BusW = 64'd42; RA = {5'd0, 5'd4};
`ifdef REGFILE_BYPASS_EN
    sb.push_back(64'd42);
`else
    sb.push_back(64'd11);
`endif
    sb.push_back(64'd42);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL bypass_same_cycle: got %0d expected %0d", BusA[63:0], exp_v); end
    tick();
    idle(); RA = {5'd0, 5'd4}; #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL bypass_next_cycle: got %0d expected %0d", BusA[63:0], exp_v); end
    RegWr = 1'b1; RW = 5'd4; BusW = 64'd43; Reserve = 1'b1; ResAddr = 5'd4; RA = {5'd4, 5'd0};
`ifdef REGFILE_BYPASS_EN
    sb.push_back(64'd43); sb.push_back(64'h1);
`else
    sb.push_back(64'd42); sb.push_back(64'h0);
`endif
    #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[127:64] !== exp_v) begin errors++; $display("FAIL bypass_res_data: got %0d expected %0d", BusA[127:64], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({63'b0, RdBusy[1]} !== exp_v) begin errors++; $display("FAIL bypass_res_busy: got %b expected %h", RdBusy[1], exp_v); end
    tick();
    idle(); RegWr = 1'b1; RW = 5'd4; BusW = 64'd43; RA = '0;
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    RA = '0; RegWr = 1'b1; RW = 5'd1; BusW = 64'd77;
    tick();
    idle(); Reserve = 1'b1; ResAddr = 5'd1; tick();
    ResAddr = 5'd2; tick();
    ResAddr = 5'd6; tick();
    idle(); RA = {5'd2, 5'd1}; #1;
    sb.push_back(64'd3); sb.push_back(64'd77);
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL pre_reset_pend: got %0d expected %0d", PendCnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL pre_reset_r1: got %0d expected %0d", BusA[63:0], exp_v); end
    #1; Reset = 1'b1; #1;
    sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0);
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL async_pend: got %0d expected %0d", PendCnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({62'b0, RdBusy} !== exp_v) begin errors++; $display("FAIL async_busy: got %b expected %h", RdBusy, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL async_r1: got %0d expected %0d", BusA[63:0], exp_v); end
    RegWr = 1'b1; RW = 5'd9; BusW = 64'd5; Reserve = 1'b1; ResAddr = 5'd9; RA = {5'd0, 5'd9};
    tick();
    idle(); #1;
    sb.push_back(64'h0); sb.push_back(64'h0);
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL reset_ignores_wr: got %0d expected %0d", BusA[63:0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({58'b0, PendCnt} !== exp_v) begin errors++; $display("FAIL reset_ignores_res: got %0d expected %0d", PendCnt, exp_v); end
    Reset = 1'b0;
    RegWr = 1'b1; RW = 5'd9; BusW = 64'd5; RA = '0;
    sb.push_back(64'd5);
    tick();
    idle(); RA = {5'd0, 5'd9}; #1;
    exp_v = sb.pop_front(); checks++;
    if (BusA[63:0] !== exp_v) begin errors++; $display("FAIL first_edge_after_reset: got %0d expected %0d", BusA[63:0], exp_v); end
  endtask

  initial begin
    Reset = 1'b1; RA = '0;
    idle();
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_reserve_clear();
    test_back_to_back();
    test_bypass();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
